// File: rtl/calc_entry_ctrl.sv
// calc_entry_ctrl
//   Keypad entry controller for the calculator datapath. Decoded key events
//   drive an operand-A / operator / operand-B / result sequence. The two-digit
//   operand registers, their binary values, the one-hot operation code and the
//   display phase code are all registered and feed the digit mux directly.
//
// Ports
//   clk          system clock
//   reset        asynchronous, active-high reset
//   key_valid    one-cycle strobe qualifying key_code
//   key_code     0-9 digit, 10 add, 11 sub, 12 mul, 13 clear, 14 backspace, 15 equals
//   tens_mem_1   operand A tens digit (BLANK_CODE when empty)
//   ones_mem_1   operand A ones digit (BLANK_CODE when empty)
//   tens_mem_2   operand B tens digit (BLANK_CODE when empty)
//   ones_mem_2   operand B ones digit (BLANK_CODE when empty)
//   num_state    display phase: 000 ENTER_A, 010 ENTER_B, 011 RESULT
//   arithmetic   one-hot operation: bit0 add, bit1 sub, bit2 mul
//   operand_a    binary value of operand A (blank digits count as 0)
//   operand_b    binary value of operand B (blank digits count as 0)
//   result_valid one-cycle pulse on entry to (or re-entry of) RESULT
//   key_err      one-cycle pulse when a strobed key is ignored
module calc_entry_ctrl #(
    parameter int DIGIT_W    = 5,
    parameter int BLANK_CODE = 11
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               key_valid,
    input  logic [3:0]         key_code,
    output logic [DIGIT_W-1:0] tens_mem_1,
    output logic [DIGIT_W-1:0] ones_mem_1,
    output logic [DIGIT_W-1:0] tens_mem_2,
    output logic [DIGIT_W-1:0] ones_mem_2,
    output logic [2:0]         num_state,
    output logic [4:0]         arithmetic,
    output logic [6:0]         operand_a,
    output logic [6:0]         operand_b,
    output logic               result_valid,
    output logic               key_err
);

    localparam logic [DIGIT_W-1:0] BLANK = DIGIT_W'(BLANK_CODE);

    typedef enum logic [2:0] {
        ENTER_A = 3'b000,
        ENTER_B = 3'b010,
        RESULT  = 3'b011
    } state_t;

    state_t             state_q, state_d;
    logic [DIGIT_W-1:0] a_tens_q, a_tens_d, a_ones_q, a_ones_d;
    logic [DIGIT_W-1:0] b_tens_q, b_tens_d, b_ones_q, b_ones_d;
    logic [4:0]         arith_q, arith_d;
    logic [6:0]         opa_q, opa_d, opb_q, opb_d;
    logic               rv_q, rv_d, err_q, err_d;

    logic [DIGIT_W-1:0] dig;
    logic               is_digit, is_op;
    logic [4:0]         op_onehot;
    logic [1:0]         a_cnt, b_cnt;

    // Digit count is implied by which registers are blank: ones fills first.
    function automatic logic [1:0] digit_count(input logic [DIGIT_W-1:0] tens,
                                               input logic [DIGIT_W-1:0] ones);
        if (ones == BLANK)      return 2'd0;
        else if (tens == BLANK) return 2'd1;
        else                    return 2'd2;
    endfunction

    function automatic logic [6:0] digit_value(input logic [DIGIT_W-1:0] tens,
                                               input logic [DIGIT_W-1:0] ones);
        logic [6:0] t, o;
        t = (tens == BLANK) ? '0 : 7'(tens);
        o = (ones == BLANK) ? '0 : 7'(ones);
        return t * 7'd10 + o;
    endfunction

    assign dig      = DIGIT_W'(key_code);
    assign is_digit = (key_code <= 4'd9);
    assign is_op    = (key_code >= 4'd10) && (key_code <= 4'd12);
    assign a_cnt    = digit_count(a_tens_q, a_ones_q);
    assign b_cnt    = digit_count(b_tens_q, b_ones_q);

    always_comb begin
        op_onehot = '0;
        case (key_code)
            4'd10:   op_onehot = 5'b00001;
            4'd11:   op_onehot = 5'b00010;
            4'd12:   op_onehot = 5'b00100;
            default: op_onehot = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        a_tens_d = a_tens_q;
        a_ones_d = a_ones_q;
        b_tens_d = b_tens_q;
        b_ones_d = b_ones_q;
        arith_d  = arith_q;
        rv_d     = 1'b0;
        err_d    = 1'b0;

        if (key_valid) begin
            if (key_code == 4'd13) begin
                state_d  = ENTER_A;
                a_tens_d = BLANK;
                a_ones_d = BLANK;
                b_tens_d = BLANK;
                b_ones_d = BLANK;
                arith_d  = '0;
            end else begin
                case (state_q)
                    ENTER_A: begin
                        if (is_digit) begin
                            if (a_cnt == 2'd0) begin
                                a_ones_d = dig;
                            end else if (a_cnt == 2'd1) begin
                                a_tens_d = a_ones_q;
                                a_ones_d = dig;
                            end else begin
                                err_d = 1'b1;
                            end
                        end else if (is_op) begin
                            if (a_cnt != 2'd0) begin
                                arith_d  = op_onehot;
                                state_d  = ENTER_B;
                                b_tens_d = BLANK;
                                b_ones_d = BLANK;
                            end else begin
                                err_d = 1'b1;
                            end
                        end else if (key_code == 4'd14) begin
                            if (a_cnt == 2'd2) begin
                                a_ones_d = a_tens_q;
                                a_tens_d = BLANK;
                            end else if (a_cnt == 2'd1) begin
                                a_ones_d = BLANK;
                            end else begin
                                err_d = 1'b1;
                            end
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    ENTER_B: begin
                        if (is_digit) begin
                            if (b_cnt == 2'd0) begin
                                b_ones_d = dig;
                            end else if (b_cnt == 2'd1) begin
                                b_tens_d = b_ones_q;
                                b_ones_d = dig;
                            end else begin
                                err_d = 1'b1;
                            end
                        end else if (is_op) begin
                            arith_d = op_onehot;
                        end else if (key_code == 4'd14) begin
                            if (b_cnt == 2'd2) begin
                                b_ones_d = b_tens_q;
                                b_tens_d = BLANK;
                            end else if (b_cnt == 2'd1) begin
                                b_ones_d = BLANK;
                            end else begin
                                // Backing out of an empty B returns to A editing.
                                state_d = ENTER_A;
                                arith_d = '0;
                            end
                        end else begin
                            if (b_cnt != 2'd0) begin
                                state_d = RESULT;
                                rv_d    = 1'b1;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                    end
                    RESULT: begin
                        if (is_digit) begin
                            state_d  = ENTER_A;
                            a_tens_d = BLANK;
                            a_ones_d = dig;
                            b_tens_d = BLANK;
                            b_ones_d = BLANK;
                            arith_d  = '0;
                        end else if (key_code == 4'd15) begin
                            rv_d = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    default: state_d = ENTER_A;
                endcase
            end
        end

        // Values are taken from the next digit contents so they update on the
        // same edge as the digit registers.
        opa_d = digit_value(a_tens_d, a_ones_d);
        opb_d = digit_value(b_tens_d, b_ones_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ENTER_A;
            a_tens_q <= BLANK;
            a_ones_q <= BLANK;
            b_tens_q <= BLANK;
            b_ones_q <= BLANK;
            arith_q  <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            rv_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_tens_q <= a_tens_d;
            a_ones_q <= a_ones_d;
            b_tens_q <= b_tens_d;
            b_ones_q <= b_ones_d;
            arith_q  <= arith_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            rv_q     <= rv_d;
            err_q    <= err_d;
        end
    end

    assign tens_mem_1   = a_tens_q;
    assign ones_mem_1   = a_ones_q;
    assign tens_mem_2   = b_tens_q;
    assign ones_mem_2   = b_ones_q;
    assign num_state    = state_q;
    assign arithmetic   = arith_q;
    assign operand_a    = opa_q;
    assign operand_b    = opb_q;
    assign result_valid = rv_q;
    assign key_err      = err_q;

endmodule

// File: tb/tb_calc_entry_ctrl.sv
// tb_calc_entry_ctrl
//   Self-checking bench for calc_entry_ctrl. Table-driven key vectors with
//   expected output records pushed to a scoreboard queue when driven and
//   popped when the outputs are sampled, plus hand sequences for async reset,
//   reset/key collision and a key strobe held for two cycles.
module tb_calc_entry_ctrl;

    localparam int BL = 11;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = '0;
    logic [4:0] tens_mem_1, ones_mem_1, tens_mem_2, ones_mem_2;
    logic [2:0] num_state;
    logic [4:0] arithmetic;
    logic [6:0] operand_a, operand_b;
    logic       result_valid, key_err;

    calc_entry_ctrl #(.DIGIT_W(5), .BLANK_CODE(11)) dut (
        .clk          (clk),
        .reset        (reset),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .tens_mem_1   (tens_mem_1),
        .ones_mem_1   (ones_mem_1),
        .tens_mem_2   (tens_mem_2),
        .ones_mem_2   (ones_mem_2),
        .num_state    (num_state),
        .arithmetic   (arithmetic),
        .operand_a    (operand_a),
        .operand_b    (operand_b),
        .result_valid (result_valid),
        .key_err      (key_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] t1, o1, t2, o2;
        logic [2:0] st;
        logic [4:0] ar;
        logic [6:0] opa, opb;
        logic       rv, err;
    } out_t;

    typedef struct {
        logic       kv;
        logic [3:0] key;
        out_t       exp;
    } vec_t;

    vec_t vecs[$];
    out_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    function automatic out_t mk(int t1, int o1, int t2, int o2, int st, int ar,
                                int opa, int opb, int rv, int err);
        out_t r;
        r.t1 = 5'(t1); r.o1 = 5'(o1); r.t2 = 5'(t2); r.o2 = 5'(o2);
        r.st = 3'(st); r.ar = 5'(ar); r.opa = 7'(opa); r.opb = 7'(opb);
        r.rv = 1'(rv); r.err = 1'(err);
        return r;
    endfunction

    function automatic out_t cur();
        out_t r;
        r.t1 = tens_mem_1; r.o1 = ones_mem_1; r.t2 = tens_mem_2; r.o2 = ones_mem_2;
        r.st = num_state;  r.ar = arithmetic; r.opa = operand_a; r.opb = operand_b;
        r.rv = result_valid; r.err = key_err;
        return r;
    endfunction

    task automatic add(input logic kv, input int key, input out_t e);
        vec_t v;
        v.kv = kv; v.key = 4'(key); v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic check(input string name);
        out_t a, e;
        a = cur();
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL %s: scoreboard empty, actual=%h", name, a);
        end else begin
            e = exp_q.pop_front();
            if (a !== e) begin
                fails++;
                $display("FAIL %s: actual t1=%0d o1=%0d t2=%0d o2=%0d st=%b ar=%b a=%0d b=%0d rv=%b err=%b | required t1=%0d o1=%0d t2=%0d o2=%0d st=%b ar=%b a=%0d b=%0d rv=%b err=%b",
                         name, a.t1, a.o1, a.t2, a.o2, a.st, a.ar, a.opa, a.opb, a.rv, a.err,
                         e.t1, e.o1, e.t2, e.o2, e.st, e.ar, e.opa, e.opb, e.rv, e.err);
            end
        end
    endtask

    // One clock step: drive at negedge, push expectation, sample 1 time unit after the edge.
    task automatic step(input logic kv, input logic [3:0] key, input out_t e, input string name);
        @(negedge clk);
        key_valid = kv;
        key_code  = key;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        check(name);
    endtask

    out_t RST;

    initial begin
        RST = mk(BL, BL, BL, BL, 0, 0, 0, 0, 0, 0);

        // A entry, third digit rejected
        add(1, 4,  mk(BL, 4, BL, BL, 0, 0, 4, 0, 0, 0));
        add(1, 2,  mk(4, 2, BL, BL, 0, 0, 42, 0, 0, 0));
        add(1, 7,  mk(4, 2, BL, BL, 0, 0, 42, 0, 0, 1));
        add(0, 0,  mk(4, 2, BL, BL, 0, 0, 42, 0, 0, 0));
        add(1, 15, mk(4, 2, BL, BL, 0, 0, 42, 0, 0, 1));
        add(1, 13, RST);
        // full add sequence into RESULT
        add(1, 9,  mk(BL, 9, BL, BL, 0, 0, 9, 0, 0, 0));
        add(1, 10, mk(BL, 9, BL, BL, 2, 1, 9, 0, 0, 0));
        add(1, 1,  mk(BL, 9, BL, 1, 2, 1, 9, 1, 0, 0));
        add(1, 5,  mk(BL, 9, 1, 5, 2, 1, 9, 15, 0, 0));
        add(1, 15, mk(BL, 9, 1, 5, 3, 1, 9, 15, 1, 0));
        add(0, 0,  mk(BL, 9, 1, 5, 3, 1, 9, 15, 0, 0));
        add(1, 15, mk(BL, 9, 1, 5, 3, 1, 9, 15, 1, 0));
        add(1, 12, mk(BL, 9, 1, 5, 3, 1, 9, 15, 0, 1));
        add(1, 14, mk(BL, 9, 1, 5, 3, 1, 9, 15, 0, 1));
        add(1, 6,  mk(BL, 6, BL, BL, 0, 0, 6, 0, 0, 0));
        // backspace out of empty B and through A
        add(1, 13, RST);
        add(1, 3,  mk(BL, 3, BL, BL, 0, 0, 3, 0, 0, 0));
        add(1, 11, mk(BL, 3, BL, BL, 2, 2, 3, 0, 0, 0));
        add(1, 14, mk(BL, 3, BL, BL, 0, 0, 3, 0, 0, 0));
        add(1, 14, RST);
        add(1, 14, mk(BL, BL, BL, BL, 0, 0, 0, 0, 0, 1));
        add(1, 10, mk(BL, BL, BL, BL, 0, 0, 0, 0, 0, 1));
        // leading zero and two-digit backspace on A
        add(1, 0,  mk(BL, 0, BL, BL, 0, 0, 0, 0, 0, 0));
        add(1, 5,  mk(0, 5, BL, BL, 0, 0, 5, 0, 0, 0));
        add(1, 14, mk(BL, 0, BL, BL, 0, 0, 0, 0, 0, 0));
        add(1, 13, RST);
        // operator replacement, empty-B equals, B edits, clear in ENTER_B
        add(1, 7,  mk(BL, 7, BL, BL, 0, 0, 7, 0, 0, 0));
        add(1, 12, mk(BL, 7, BL, BL, 2, 4, 7, 0, 0, 0));
        add(1, 10, mk(BL, 7, BL, BL, 2, 1, 7, 0, 0, 0));
        add(1, 15, mk(BL, 7, BL, BL, 2, 1, 7, 0, 0, 1));
        add(1, 8,  mk(BL, 7, BL, 8, 2, 1, 7, 8, 0, 0));
        add(1, 0,  mk(BL, 7, 8, 0, 2, 1, 7, 80, 0, 0));
        add(1, 3,  mk(BL, 7, 8, 0, 2, 1, 7, 80, 0, 1));
        add(1, 14, mk(BL, 7, BL, 8, 2, 1, 7, 8, 0, 0));
        add(1, 9,  mk(BL, 7, 8, 9, 2, 1, 7, 89, 0, 0));
        add(1, 13, RST);

        // reset state
        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back(RST);
        check("reset_state");
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++)
            step(vecs[i].kv, vecs[i].key, vecs[i].exp, $sformatf("vec[%0d]", i));

        // async reset mid-cycle in ENTER_B with B=8
        step(1'b1, 4'd1,  mk(BL, 1, BL, BL, 0, 0, 1, 0, 0, 0), "ar_a1");
        step(1'b1, 4'd10, mk(BL, 1, BL, BL, 2, 1, 1, 0, 0, 0), "ar_add");
        step(1'b1, 4'd8,  mk(BL, 1, BL, 8, 2, 1, 1, 8, 0, 0), "ar_b8");
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        exp_q.push_back(RST);
        check("async_reset");
        // key coincident with reset held across an edge is dropped
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = 4'd5;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        exp_q.push_back(RST);
        check("key_during_reset");
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        exp_q.push_back(RST);
        check("after_reset_release");

        // strobe held two cycles counts as two keys
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = 4'd3;
        @(posedge clk);
        #1;
        exp_q.push_back(mk(BL, 3, BL, BL, 0, 0, 3, 0, 0, 0));
        check("held_key_1");
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        exp_q.push_back(mk(3, 3, BL, BL, 0, 0, 33, 0, 0, 0));
        check("held_key_2");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1);
    end

endmodule

// File: doc/calc_entry_ctrl.md
Name: calc_entry_ctrl

Overview:
Keypad-driven entry controller for the calculator datapath. It takes decoded key events and runs the three-phase entry sequence: operand A, then operator, then operand B, then result. It holds the two-digit operand registers, the selected operation code and the display phase code. All of these feed the downstream display/arithmetic digit mux directly.

Parameters:
DIGIT_W, 5, width of each stored digit register
BLANK_CODE, 11, digit value that the seven-seg decoder renders as all segments off

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
key_valid  input  1  one-cycle strobe; key_code is valid this cycle (already debounced and synchronised)
key_code  input  4  0-9 digit; 10 add; 11 subtract; 12 multiply; 13 clear; 14 backspace; 15 equals
tens_mem_1  output  DIGIT_W  operand A tens digit or BLANK_CODE
ones_mem_1  output  DIGIT_W  operand A ones digit or BLANK_CODE
tens_mem_2  output  DIGIT_W  operand B tens digit or BLANK_CODE
ones_mem_2  output  DIGIT_W  operand B ones digit or BLANK_CODE
num_state  output  3  display phase: 3'b000 ENTER_A, 3'b010 ENTER_B, 3'b011 RESULT
arithmetic  output  5  one-hot operation: bit0 add, bit1 sub, bit2 mul; 5'b00000 none
operand_a  output  7  binary value of A (0-99), blank digits count as 0
operand_b  output  7  binary value of B (0-99), blank digits count as 0
result_valid  output  1  one-cycle pulse on entry to RESULT
key_err  output  1  one-cycle pulse when an accepted-strobe key is ignored

Behaviour:
- Clocking and reset:
  - All outputs are registered.
  - Reset values: all digit registers = BLANK_CODE, num_state = 000, arithmetic = 0, operand_a = operand_b = 0, result_valid = 0, key_err = 0.
  - Reset asserted mid-sequence discards all entry immediately, with no clock needed.
- Latency:
  - A key sampled with key_valid=1 on edge N is reflected in all outputs after edge N.
  - operand_a and operand_b are registered in the same cycle as the digit registers. There is no extra lag.
- Digit count: per operand, 0 = both digits blank, 1 = ones valid and tens blank, 2 = both valid.
- Digit key, active operand has count 0: ones <= d.
- Digit key, count 1: tens <= ones, ones <= d.
- Digit key, count 2: ignored, key_err pulses.
- A leading 0 counts as a digit. Example: "0","5" displays 0 5.
- Backspace, count 2: ones <= tens, tens <= BLANK.
- Backspace, count 1: ones <= BLANK.
- Backspace, count 0 in ENTER_B: returns to ENTER_A, arithmetic <= 0, A digits preserved.
- Backspace, count 0 in ENTER_A: ignored, key_err pulses.
- FSM ENTER_A (000):
  - Digits and backspace edit A.
  - Operator key with A count >= 1: arithmetic <= one-hot, go to ENTER_B with B blank.
  - Operator key with A count 0: key_err pulses.
  - Equals: key_err pulses.
- FSM ENTER_B (010):
  - Digits and backspace edit B.
  - Operator key replaces arithmetic, stays in ENTER_B, no error.
  - Equals with B count >= 1: go to RESULT, result_valid pulses.
  - Equals with B count 0: key_err pulses.
- FSM RESULT (011):
  - A, B and arithmetic are held.
  - Digit key: clear B and arithmetic, A <= {BLANK, d}, go to ENTER_A.
  - Equals: re-pulses result_valid, stays in RESULT.
  - Operator or backspace: key_err pulses.
- Clear (13) in any state: same values as reset, synchronous, no key_err.
- Reset and key_valid in the same cycle: reset wins, key is dropped.
- key_valid is never held high for more than one cycle. If it is, each high cycle is a separate key.
- num_state never takes values other than 000, 010 or 011.
- Operand arithmetic: value = (tens==BLANK ? 0 : tens)*10 + (ones==BLANK ? 0 : ones). Max 99 fits in 7 bits.

Test Plan:
- Reset, then keys 4, 2 -> num_state 000; tens_mem_1=4, ones_mem_1=2; operand_a=42. After a third digit 7: unchanged, key_err pulses once.
- Keys 9, add, 1, 5, equals -> arithmetic=5'b00001; B digits 1/5; operand_b=15; num_state 011; result_valid is high for exactly one cycle.
- Keys 3, sub, backspace -> back in 000; arithmetic=0; ones_mem_1=3, tens_mem_1=11. Then backspace, backspace -> A fully blank, second backspace raises key_err.
- Keys 7, mul, add -> arithmetic=5'b00001 and num_state stays 010. Equals with B empty -> key_err, still 010.
- In RESULT, digit 6 -> num_state 000; ones_mem_1=6, tens_mem_1=11; B blank; arithmetic=0. Separately, clear in ENTER_B -> all reset values.
- Assert reset asynchronously between clock edges while in ENTER_B with B=8 -> outputs take reset values before the next edge. A key_valid coincident with reset release cycle is dropped.
